// File: rtl/ibuf_ctrl.sv
// ibuf_ctrl: control path of a two-bank instruction buffer.
// Fetch pairs are steered across the banks starting at the tail bank, and
// issue drains them starting at the head bank, so program order alternates
// between the banks. Each grant reserves a slot for one cycle before the
// entry lands in the bank counter, which makes an entry issuable two cycles
// after its grant.
module ibuf_ctrl #(
  parameter int DEPTH = 128,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          stall,
  input  logic          pause,
  input  logic          fetch_req,
  input  logic [1:0]    fetch_valid,
  input  logic [1:0]    issue_cap,
  output logic [1:0]    icache_fetch_inst_en,
  output logic          push_swap,
  output logic [1:0]    send_inst_en,
  output logic          issue_swap,
  output logic [CW-1:0] occ0,
  output logic [CW-1:0] occ1,
  output logic          ibuf_empty,
  output logic          ibuf_full
);

  localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

  logic [1:0][CW-1:0] cnt_r;
  logic [1:0]         pend_r;
  logic               tl_r;
  logic               hd_r;

  logic [1:0][CW:0]   free_s;
  logic               blk_s;
  logic [1:0]         tgt_s;
  logic               room_s;
  logic               grant_s;
  logic [1:0]         cap_s;
  logic [1:0]         avail_s;
  logic [1:0]         k_s;
  logic               pop_hd_s;
  logic               pop_ot_s;
  logic [1:0]         pop_s;
  logic [1:0]         pend_nxt_s;
  logic [1:0][CW-1:0] cnt_nxt_s;

  // Free space per bank: capacity minus stored entries minus reservations.
  always_comb begin
    free_s = '0;
    for (int i = 0; i < 2; i++) begin
      free_s[i] = DEPTH_W - {1'b0, cnt_r[i]} - {{CW{1'b0}}, pend_r[i]};
    end
  end

  // Fetch grant: slot0 targets the tail bank, slot1 the other bank; all-or-nothing.
  always_comb begin
    blk_s   = stall | pause | flush | ~rst;
    tgt_s   = tl_r ? {fetch_valid[0], fetch_valid[1]} : fetch_valid;
    room_s  = (~tgt_s[0] | (free_s[0] != {(CW+1){1'b0}})) &
              (~tgt_s[1] | (free_s[1] != {(CW+1){1'b0}}));
    grant_s = fetch_req & ~blk_s & fetch_valid[0] & room_s;
    if (grant_s) begin
      pend_nxt_s = tgt_s;
    end else begin
      pend_nxt_s = 2'b00;
    end
  end

  // Issue count: limited by what the head bank and its partner can supply.
  always_comb begin
    cap_s   = (issue_cap == 2'd3) ? 2'd2 : issue_cap;
    avail_s = 2'd0;
    if (cnt_r[hd_r] == {CW{1'b0}}) begin
      avail_s = 2'd0;
    end else if (cnt_r[~hd_r] == {CW{1'b0}}) begin
      avail_s = 2'd1;
    end else begin
      avail_s = 2'd2;
    end
    if (blk_s) begin
      k_s = 2'd0;
    end else if (cap_s < avail_s) begin
      k_s = cap_s;
    end else begin
      k_s = avail_s;
    end
    pop_hd_s = (k_s != 2'd0);
    pop_ot_s = (k_s == 2'd2);
    pop_s    = hd_r ? {pop_hd_s, pop_ot_s} : {pop_ot_s, pop_hd_s};
  end

  // Next counter value: landing reservation in, popped entry out, same edge.
  always_comb begin
    cnt_nxt_s = '0;
    for (int i = 0; i < 2; i++) begin
      cnt_nxt_s[i] = cnt_r[i] + {{(CW-1){1'b0}}, pend_r[i]}
                              - {{(CW-1){1'b0}}, pop_s[i]};
    end
  end

  // Buffer state: counters, reservations and the head/tail bank pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r  <= '0;
      pend_r <= 2'b00;
      tl_r   <= 1'b0;
      hd_r   <= 1'b0;
    end else if (flush) begin
      cnt_r  <= '0;
      pend_r <= 2'b00;
      tl_r   <= 1'b0;
      hd_r   <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      pend_r <= pend_nxt_s;
      tl_r   <= tl_r ^ (grant_s & (fetch_valid == 2'b01));
      hd_r   <= hd_r ^ (k_s == 2'd1);
    end
  end

  // Output drive: grants and pops act in the request cycle; status from state.
  always_comb begin
    if (grant_s) begin
      icache_fetch_inst_en = fetch_valid;
    end else begin
      icache_fetch_inst_en = 2'b00;
    end
    push_swap    = tl_r;
    send_inst_en = pop_s;
    issue_swap   = hd_r;
    occ0         = cnt_r[0];
    occ1         = cnt_r[1];
    ibuf_empty   = (cnt_r[0] == {CW{1'b0}}) & (cnt_r[1] == {CW{1'b0}});
    ibuf_full    = (free_s[0] == {(CW+1){1'b0}}) | (free_s[1] == {(CW+1){1'b0}});
  end

endmodule

// File: doc/ibuf_ctrl.md
IBUF_CTRL -- requirements
Module: ibuf_ctrl

Interface
REQ-001 Parameter DEPTH, default 128, SHALL set the entry capacity of each of the two instruction-buffer banks.
REQ-002 Parameter CW, default 8, SHALL set the per-bank counter width, which must be at least clog2(DEPTH+1).
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset; rst=0 SHALL reset all state immediately, independent of clk.
REQ-005 flush  in  1  pipeline redirect; discards all buffered and reserved entries.
REQ-006 stall  in  1  back-end stall; blocks fetch grant and issue.
REQ-007 pause  in  1  front-end pause; blocks fetch grant and issue.
REQ-008 fetch_req  in  1  BPU/icache requests to deliver an instruction pair.
REQ-009 fetch_valid  in  2  valid slots of the pair; legal values are 00, 01 and 11.
REQ-010 issue_cap  in  2  number of instructions the decoder accepts this cycle (0..2); value 3 SHALL be treated as 2.
REQ-011 icache_fetch_inst_en  out  2  per-slot push grant to the buffer.
REQ-012 push_swap  out  1  slot steering; 1 means slot0 goes to bank1 and slot1 goes to bank0.
REQ-013 send_inst_en  out  2  per-bank pop enable.
REQ-014 issue_swap  out  1  1 means bank1 holds the oldest issued instruction (it is output slot 0).
REQ-015 occ0, occ1  out  CW each  stored entry count of bank0 and bank1.
REQ-016 ibuf_empty  out  1  both banks have zero stored entries.
REQ-017 ibuf_full  out  1  the next two-slot fetch cannot be granted.

Function
REQ-018 State SHALL consist of: cnt[1:0] (stored entries per bank), pend[1:0] (1-cycle reservation per bank), tl (tail bank) and hd (head bank).
REQ-019 free[i] SHALL equal DEPTH - cnt[i] - pend[i].
REQ-020 Fetch need: for slot k with fetch_valid[k]=1, the target bank SHALL be tl^k.
REQ-021 Fetch SHALL be granted iff fetch_req & !stall & !pause & !flush & fetch_valid!=00/10 & free of every target bank >= 1.
- Grant is all-or-nothing: no partial grants.
REQ-022 On grant, the outputs SHALL be:
- icache_fetch_inst_en = fetch_valid;
- push_swap = tl;
- pend[target] set for the next cycle;
- tl toggles iff fetch_valid==01.
REQ-023 When there is no grant, icache_fetch_inst_en SHALL be 00, push_swap SHALL equal tl, and tl SHALL hold.
REQ-024 Push latency is 1 cycle: a pend bit set at cycle t SHALL add 1 to cnt at edge t+1 and clear.
- An entry becomes issuable no earlier than cycle t+2.
REQ-025 Issue availability SHALL be computed as follows:
- avail = 0 if cnt[hd]==0;
- avail = 1 if cnt[hd]>0 and cnt[!hd]==0;
- avail = 2 otherwise.
REQ-026 Issue count k SHALL equal min(avail, issue_cap) when !stall & !pause & !flush, else 0.
REQ-027 send_inst_en bits SHALL be driven as follows:
- k>=1 sets send_inst_en[hd];
- k==2 also sets send_inst_en[!hd];
- issue_swap = hd;
- hd toggles iff k==1.
REQ-028 A bank receiving a push and a pop in the same cycle SHALL update cnt[i] += pend[i] - pop[i] in one edge; cnt SHALL never exceed DEPTH or underflow.
REQ-029 Flush SHALL dominate every other input in its cycle:
- all outputs grant/pop zero;
- at the edge, cnt, pend, hd and tl clear to 0;
- reservations made in the flush cycle SHALL not be counted.
REQ-030 occ0/occ1 SHALL equal the registered cnt values.
REQ-031 ibuf_full SHALL equal (free[0]==0) | (free[1]==0).
REQ-032 ibuf_empty SHALL equal (cnt[0]==0) & (cnt[1]==0).
REQ-033 The order invariant SHALL hold: the global program order is hd, !hd, hd, ... and |cnt[0]-cnt[1]| <= 1 whenever pend==00.

Reset
REQ-034 While rst=0, the following SHALL hold:
- cnt=0, pend=0, hd=0, tl=0;
- icache_fetch_inst_en=00, send_inst_en=00, push_swap=0, issue_swap=0;
- occ0=occ1=0, ibuf_empty=1, ibuf_full=0.
REQ-035 Reset assertion mid-operation SHALL discard all reservations.
- The first grant is possible in the first cycle after rst rises.
REQ-036 There SHALL be no X on any output after reset.

Verification
REQ-037 The bench SHALL cover: reset, then fetch_req=1, fetch_valid=11, issue_cap=0 for 3 cycles -> grants 11 each cycle; occ0=occ1=3 two cycles after the last grant.
REQ-038 The bench SHALL cover: single-slot fetch 01 twice from empty -> first grant uses push_swap=0 and the second uses push_swap=1; then issue_cap=2 -> send_inst_en=11 with issue_swap=0.
REQ-039 The bench SHALL cover: odd occupancy (bank0=1, bank1=0) with issue_cap=2 -> send_inst_en=01, hd->1; the next issue presents bank1 as slot 0 (issue_swap=1).
REQ-040 The bench SHALL cover: fill both banks to DEPTH-1, then a fetch of 11 -> granted, ibuf_full=1; the next fetch is blocked until one pop, and the count never exceeds 128.
REQ-041 The bench SHALL cover: flush asserted in the same cycle as a grant request and issue_cap=2 -> both enables 00; the next cycle occ0=occ1=0, hd=tl=0.
REQ-042 The bench SHALL cover: stall=1 with 4 entries stored and fetch_req=1 -> no grant and no pop while stall holds; state is unchanged and resumes exactly when stall drops.
